mem_sram_arb2: RTL and testbench

//  Two-requester round-robin arbiter sharing one single-port synchronous SRAM
//  (WIDTH-bit words, byte strobes, 1-cycle read latency, registered err).

---
 rtl/mem_sram_arb2_pkg.sv | 18 +
 rtl/mem_sram_arb2_arb_rr2.sv | 53 +++++
 rtl/mem_sram_arb2.sv | 104 ++++++++++
 tb/tb_mem_sram_arb2.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_sram_arb2_pkg.sv
// rtl/mem_sram_arb2_pkg.sv - shared types and defaults for the two-port SRAM arbiter
package mem_sram_arb2_pkg;

  localparam int unsigned DEF_WIDTH = 64;
  localparam int unsigned DEF_DEPTH = 1024;

  // Identifies which requester owns a grant or an in-flight response
  typedef enum logic {
    PORT_P0 = 1'b0,
    PORT_P1 = 1'b1
  } port_e;

  // Word-address width for a memory of the given depth (at least one bit)
  function automatic int unsigned addr_bits(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_sram_arb2_arb_rr2.sv
// rtl/mem_sram_arb2_arb_rr2.sv - two-way round-robin grant logic with last-grant pointer
module arb_rr2
  import mem_sram_arb2_pkg::*;
#(
  parameter bit PRIO0 = 1'b1  // 1: p0 wins the first conflict after reset, 0: p1 does
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  req0,
  input  logic  req1,
  output logic  gnt0,
  output logic  gnt1,
  output port_e gnt_port
);

  // Requester granted most recently; the other one wins the next conflict
  port_e last_q;
  port_e last_d;

  // Grant selection: lone requester wins, conflicts go to the port not granted last
  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    gnt_port = PORT_P0;
    last_d   = last_q;
    if (!reset) begin
      if (req0 && req1) begin
        gnt_port = (last_q == PORT_P0) ? PORT_P1 : PORT_P0;
        gnt0     = (gnt_port == PORT_P0);
        gnt1     = (gnt_port == PORT_P1);
        last_d   = gnt_port;
      end else if (req0) begin
        gnt0     = 1'b1;
        gnt_port = PORT_P0;
        last_d   = PORT_P0;
      end else if (req1) begin
        gnt1     = 1'b1;
        gnt_port = PORT_P1;
        last_d   = PORT_P1;
      end
    end
  end

  // Pointer register; reset pretends the other port was served so PRIO0 wins first
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= PRIO0 ? PORT_P1 : PORT_P0;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_sram_arb2.sv
// rtl/mem_sram_arb2.sv - round-robin arbiter sharing one single-port SRAM between two requesters
module mem_sram_arb2
  import mem_sram_arb2_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter bit          PRIO0 = 1'b1,
  localparam int unsigned AW   = addr_bits(DEPTH),
  localparam int unsigned NB   = WIDTH / 8
) (
  input  logic             g_clk,
  input  logic             g_reset,
  // fetch port
  input  logic             p0_req,
  output logic             p0_gnt,
  input  logic [NB-1:0]    p0_wstrb,
  input  logic [AW-1:0]    p0_addr,
  input  logic [WIDTH-1:0] p0_wdata,
  output logic             p0_rvalid,
  output logic [WIDTH-1:0] p0_rdata,
  output logic             p0_err,
  // data port
  input  logic             p1_req,
  output logic             p1_gnt,
  input  logic [NB-1:0]    p1_wstrb,
  input  logic [AW-1:0]    p1_addr,
  input  logic [WIDTH-1:0] p1_wdata,
  output logic             p1_rvalid,
  output logic [WIDTH-1:0] p1_rdata,
  output logic             p1_err,
  // memory side
  output logic             m_cen,
  output logic [NB-1:0]    m_wstrb,
  output logic [AW-1:0]    m_addr,
  output logic [WIDTH-1:0] m_wdata,
  input  logic [WIDTH-1:0] m_rdata,
  input  logic             m_err
);

  port_e gnt_port;

  // Response tracking: one access in flight at most, answered the next cycle
  logic  rsp_vld_q;
  logic  rsp_vld_d;
  port_e rsp_sel_q;
  port_e rsp_sel_d;

  arb_rr2 #(
    .PRIO0 (PRIO0)
  ) u_arb (
    .clk      (g_clk),
    .reset    (g_reset),
    .req0     (p0_req),
    .req1     (p1_req),
    .gnt0     (p0_gnt),
    .gnt1     (p1_gnt),
    .gnt_port (gnt_port)
  );

  // Memory request mux: the granted requester drives the SRAM, idle cycles drive zeros
  always_comb begin
    m_cen   = p0_gnt | p1_gnt;
    m_wstrb = '0;
    m_addr  = '0;
    m_wdata = '0;
    if (p0_gnt) begin
      m_wstrb = p0_wstrb;
      m_addr  = p0_addr;
      m_wdata = p0_wdata;
    end else if (p1_gnt) begin
      m_wstrb = p1_wstrb;
      m_addr  = p1_addr;
      m_wdata = p1_wdata;
    end
  end

  // Next response owner follows this cycle's grant
  always_comb begin
    rsp_vld_d = p0_gnt | p1_gnt;
    rsp_sel_d = gnt_port;
  end

  // Response register; reset drops whatever was in flight
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      rsp_vld_q <= 1'b0;
      rsp_sel_q <= PORT_P0;
    end else begin
      rsp_vld_q <= rsp_vld_d;
      rsp_sel_q <= rsp_sel_d;
    end
  end

  // Response demux; a cycle spent in reset never delivers a response
  always_comb begin
    p0_rvalid = rsp_vld_q && (rsp_sel_q == PORT_P0) && !g_reset;
    p1_rvalid = rsp_vld_q && (rsp_sel_q == PORT_P1) && !g_reset;
    p0_rdata  = p0_rvalid ? m_rdata : '0;
    p1_rdata  = p1_rvalid ? m_rdata : '0;
    p0_err    = p0_rvalid & m_err;
    p1_err    = p1_rvalid & m_err;
  end

endmodule

// File: tb/tb_mem_sram_arb2.sv
// tb/tb_mem_sram_arb2.sv - self-checking bench for mem_sram_arb2
module tb_mem_sram_arb2;

  localparam int WIDTH = 64;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int NB    = 8;
  localparam bit PRIO0 = 1'b1;

  logic             g_clk;
  logic             g_reset;
  logic             p0_req, p0_gnt, p0_rvalid, p0_err;
  logic [NB-1:0]    p0_wstrb;
  logic [AW-1:0]    p0_addr;
  logic [WIDTH-1:0] p0_wdata, p0_rdata;
  logic             p1_req, p1_gnt, p1_rvalid, p1_err;
  logic [NB-1:0]    p1_wstrb;
  logic [AW-1:0]    p1_addr;
  logic [WIDTH-1:0] p1_wdata, p1_rdata;
  logic             m_cen, m_err;
  logic [NB-1:0]    m_wstrb;
  logic [AW-1:0]    m_addr;
  logic [WIDTH-1:0] m_wdata, m_rdata;

  mem_sram_arb2 #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PRIO0(PRIO0)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .p0_req(p0_req), .p0_gnt(p0_gnt), .p0_wstrb(p0_wstrb), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_gnt(p1_gnt), .p1_wstrb(p1_wstrb), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .m_cen(m_cen), .m_wstrb(m_wstrb), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_err(m_err)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  function automatic logic [WIDTH-1:0] preload(input int i);
    return {32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i)};
  endfunction

  // SRAM: 1-cycle read-before-write, error on writes while in ROM mode
  logic             init_mem;
  logic             rom_mode;
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge g_clk) begin
    if (init_mem) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= preload(i);
      m_rdata <= '0;
      m_err   <= 1'b0;
    end else if (m_cen) begin
      m_rdata <= mem[m_addr];
      m_err   <= rom_mode && (m_wstrb != '0);
      if (!rom_mode)
        for (int b = 0; b < NB; b++)
          if (m_wstrb[b]) mem[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
    end else begin
      m_err <= 1'b0;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: preferred port on conflict, one pending response, shadow memory
  int               prefer;
  bit               pend_v;
  int               pend_port;
  logic [WIDTH-1:0] pend_data;
  bit               pend_err;
  logic [WIDTH-1:0] shadow [DEPTH];

  // Values sampled from the DUT in the last step, for hand-written checks
  logic             s_g0, s_g1, s_rv0, s_rv1, s_err0, s_err1;
  logic [WIDTH-1:0] s_rd0, s_rd1;
  int               last_eg;

  task automatic step(input logic rst, input logic r0, input logic r1,
                      input logic [NB-1:0] s0, input logic [NB-1:0] s1,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1);
    int               eg;
    logic [AW-1:0]    ea;
    logic [NB-1:0]    es;
    logic [WIDTH-1:0] ed;
    logic             erv0, erv1;
    g_reset = rst; p0_req = r0; p1_req = r1;
    p0_wstrb = s0; p1_wstrb = s1; p0_addr = a0; p1_addr = a1;
    p0_wdata = d0; p1_wdata = d1;
    @(negedge g_clk);
    if (rst) eg = -1;
    else if (r0 && r1) eg = prefer;
    else if (r0) eg = 0;
    else if (r1) eg = 1;
    else eg = -1;
    ea = (eg == 0) ? a0 : (eg == 1) ? a1 : '0;
    es = (eg == 0) ? s0 : (eg == 1) ? s1 : '0;
    ed = (eg == 0) ? d0 : (eg == 1) ? d1 : '0;
    erv0 = !rst && pend_v && (pend_port == 0);
    erv1 = !rst && pend_v && (pend_port == 1);
    chk("p0_gnt",    64'(p0_gnt),    64'(eg == 0));
    chk("p1_gnt",    64'(p1_gnt),    64'(eg == 1));
    chk("m_cen",     64'(m_cen),     64'(eg >= 0));
    chk("m_addr",    64'(m_addr),    64'(ea));
    chk("m_wstrb",   64'(m_wstrb),   64'(es));
    chk("m_wdata",   m_wdata,        ed);
    chk("p0_rvalid", 64'(p0_rvalid), 64'(erv0));
    chk("p1_rvalid", 64'(p1_rvalid), 64'(erv1));
    chk("p0_rdata",  p0_rdata,       erv0 ? pend_data : '0);
    chk("p1_rdata",  p1_rdata,       erv1 ? pend_data : '0);
    chk("p0_err",    64'(p0_err),    64'(erv0 && pend_err));
    chk("p1_err",    64'(p1_err),    64'(erv1 && pend_err));
    s_g0 = p0_gnt; s_g1 = p1_gnt; s_rv0 = p0_rvalid; s_rv1 = p1_rvalid;
    s_rd0 = p0_rdata; s_rd1 = p1_rdata; s_err0 = p0_err; s_err1 = p1_err;
    last_eg = eg;
    @(posedge g_clk);
    if (rst) begin
      prefer = PRIO0 ? 0 : 1;
      pend_v = 0;
    end else if (eg >= 0) begin
      prefer    = 1 - eg;
      pend_v    = 1;
      pend_port = eg;
      pend_data = shadow[ea];
      pend_err  = rom_mode && (es != '0);
      if (!rom_mode)
        for (int b = 0; b < NB; b++)
          if (es[b]) shadow[ea][8*b +: 8] = ed[8*b +: 8];
    end else begin
      pend_v = 0;
    end
    #1;
  endtask

  typedef struct {
    logic          rst, r0, r1;
    logic [AW-1:0] a0, a1;
    logic          g0, g1, rv0, rv1;
  } vec_t;
  vec_t tbl [16];

  logic             h0_req, h1_req;
  logic [NB-1:0]    h0_strb, h1_strb;
  logic [AW-1:0]    h0_addr, h1_addr;
  logic [WIDTH-1:0] h0_data, h1_data, pw;

  initial begin
    // rst r0 r1 a0 a1 | g0 g1 rv0 rv1
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 6'h10, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 6'h01, 6'h02, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 6'h03, 6'h02, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 6'h03, 6'h05, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 6'h06, 6'h05, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 6'h06, 6'h07, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 6'h08, 6'h07, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 6'h09, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 6'h0A, 6'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 6'h0B, 6'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 6'h0C, 6'h0D, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 6'h0C, 6'h0E, 1'b1, 1'b0, 1'b0, 1'b1};

    prefer = PRIO0 ? 0 : 1;
    pend_v = 0; pend_port = 0; pend_data = '0; pend_err = 0; last_eg = -1;
    for (int i = 0; i < DEPTH; i++) shadow[i] = preload(i);
    rom_mode = 1'b0; init_mem = 1'b1; g_reset = 1'b1;
    p0_req = 1'b0; p1_req = 1'b0; p0_wstrb = '0; p1_wstrb = '0;
    p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0;
    @(posedge g_clk);
    #1 init_mem = 1'b0;

    // Table: reset, lone read, alternating conflicts, continuous p0 then p1 joins
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].rst, tbl[i].r0, tbl[i].r1, '0, '0, tbl[i].a0, tbl[i].a1, '0, '0);
      chk($sformatf("tbl%0d_g0", i),  64'(s_g0),  64'(tbl[i].g0));
      chk($sformatf("tbl%0d_g1", i),  64'(s_g1),  64'(tbl[i].g1));
      chk($sformatf("tbl%0d_rv0", i), 64'(s_rv0), 64'(tbl[i].rv0));
      chk($sformatf("tbl%0d_rv1", i), 64'(s_rv1), 64'(tbl[i].rv1));
      if (i == 2) chk("tbl_read_0x10", s_rd0, preload(16));
    end
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0);

    // Partial-strobe write from p1, read back on p0
    step(1'b0, 1'b0, 1'b1, '0, 8'h0F, '0, 6'd5, '0, 64'hDEADBEEF_CAFEF00D);
    step(1'b0, 1'b1, 1'b0, '0, '0, 6'd5, '0, '0, '0);
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0);
    pw = preload(5);
    chk("bytewrite_rdata", s_rd0, {pw[63:32], 32'hCAFEF00D});

    // Write to ROM reports an error on the writer only
    rom_mode = 1'b1;
    step(1'b0, 1'b0, 1'b1, '0, 8'hFF, '0, 6'd3, '0, '1);
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0);
    chk("rom_rv1",  64'(s_rv1),  64'(1));
    chk("rom_err1", 64'(s_err1), 64'(1));
    chk("rom_err0", 64'(s_err0), 64'(0));
    rom_mode = 1'b0;

    // Reset right after a grant drops the response; PRIO0 then wins the conflict
    step(1'b0, 1'b1, 1'b0, '0, '0, 6'd7, '0, '0, '0);
    step(1'b1, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0);
    chk("rst_drop_t1", 64'(s_rv0), 64'(0));
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0);
    chk("rst_drop_t2", 64'(s_rv0), 64'(0));
    step(1'b0, 1'b1, 1'b1, '0, '0, 6'd1, 6'd2, '0, '0);
    chk("rst_prio_g0", 64'(s_g0), 64'(1));
    chk("rst_prio_g1", 64'(s_g1), 64'(0));

    // Random traffic; requests stay stable until granted
    h0_req = 0; h1_req = 0; h0_strb = '0; h1_strb = '0;
    h0_addr = '0; h1_addr = '0; h0_data = '0; h1_data = '0;
    for (int c = 0; c < 800; c++) begin
      if (!(h0_req && last_eg != 0)) begin
        h0_req  = ($urandom_range(0, 3) != 0);
        h0_strb = ($urandom_range(0, 1) != 0) ? NB'($urandom) : '0;
        h0_addr = AW'($urandom_range(0, DEPTH - 1));
        h0_data = {$urandom, $urandom};
      end
      if (!(h1_req && last_eg != 1)) begin
        h1_req  = ($urandom_range(0, 3) != 0);
        h1_strb = ($urandom_range(0, 1) != 0) ? NB'($urandom) : '0;
        h1_addr = AW'($urandom_range(0, DEPTH - 1));
        h1_data = {$urandom, $urandom};
      end
      rom_mode = (c >= 600 && c < 700);
      step(($urandom_range(0, 59) == 0), h0_req, h1_req, h0_strb, h1_strb,
           h0_addr, h1_addr, h0_data, h1_data);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
